// File: rtl/rv_hazard_ctrl_if.sv
// Pipeline-sequencing bus between the RV32 pipeline (master) and rv_hazard_ctrl (slave).
// Carries the ID/EX hazard inputs, the memory handshake, the pipeline enables and the perf counters.
interface rv_hazard_ctrl_if #(
    parameter int RW = 5
);
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic          id_branch;
    logic          id_equal;
    logic          ex_memread;
    logic [RW-1:0] ex_rd;
    logic          mem_req;
    logic          dmem_ready;

    logic          pc_write;
    logic          ifid_write;
    logic          ifid_flush;
    logic          idex_bubble;
    logic          pipe_hold;
    logic          mem_err;
    logic [31:0]   perf_lduse;
    logic [31:0]   perf_memwait;
    logic [31:0]   perf_flush;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch, id_equal,
               ex_memread, ex_rd, mem_req, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_err,
               perf_lduse, perf_memwait, perf_flush
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch, id_equal,
               ex_memread, ex_rd, mem_req, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_err,
               perf_lduse, perf_memwait, perf_flush
    );
endinterface

// File: rtl/rv_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline: load-use stall, branch flush, dmem wait/timeout.
// Define RV_HAZ_PERF_EN to build the three 32-bit performance counters; otherwise they read as 0.
module rv_hazard_ctrl #(
    parameter int RW          = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int CW          = 8
) (
    input logic             clk,
    input logic             rst_n,
    rv_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

    localparam bit            TIMEOUT_EN  = (MEM_TIMEOUT != 0);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(MEM_TIMEOUT);

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt, wait_cnt_next, wait_cnt_inc;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          lu, mw;
    logic          pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c, pipe_hold_c;

    assign id_rs1 = hz.id_rs1;
    assign id_rs2 = hz.id_rs2;
    assign ex_rd  = hz.ex_rd;

    // x0 is never a real dependency, and an unread source field cannot create one.
    assign lu = hz.ex_memread && (ex_rd != '0) &&
                ((hz.id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (hz.id_use_rs2 && (id_rs2 == ex_rd)));
    assign mw = hz.mem_req && !hz.dmem_ready;

    assign wait_cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        pipe_hold_c   = 1'b0;
        case (state)
            RUN, MEMWAIT: begin
                // A MEMWAIT cycle without mw (ready, or mem_req dropped) is a release and behaves as RUN.
                if (mw) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    pipe_hold_c  = 1'b1;
                    if (state == RUN) begin
                        state_next    = MEMWAIT;
                        wait_cnt_next = CW'(1);
                    end else begin
                        wait_cnt_next = wait_cnt_inc;
                        if (TIMEOUT_EN && (wait_cnt_inc >= TIMEOUT_CNT))
                            state_next = ERR;
                    end
                end else begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                    if (lu) begin
                        pc_write_c    = 1'b0;
                        ifid_write_c  = 1'b0;
                        idex_bubble_c = 1'b1;
                    end else if (hz.id_branch && hz.id_equal) begin
                        ifid_flush_c = 1'b1;
                    end
                end
            end
            default: begin
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                pipe_hold_c  = 1'b1;
                state_next   = ERR;
            end
        endcase
    end

    // Reset forces a frozen pipeline with a NOP entering EX, independent of the clock.
    assign hz.pc_write    = rst_n && pc_write_c;
    assign hz.ifid_write  = rst_n && ifid_write_c;
    assign hz.ifid_flush  = rst_n && ifid_flush_c;
    assign hz.idex_bubble = !rst_n || idex_bubble_c;
    assign hz.pipe_hold   = !rst_n || pipe_hold_c;
    assign hz.mem_err     = (state == ERR);

`ifdef RV_HAZ_PERF_EN
    logic [31:0] cnt_lduse, cnt_memwait, cnt_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_lduse   <= '0;
            cnt_memwait <= '0;
            cnt_flush   <= '0;
        end else begin
            if (idex_bubble_c)
                cnt_lduse <= cnt_lduse + 32'd1;
            // Memory-induced hold cycles only; the ERR freeze is not a wait.
            if (pipe_hold_c && (state != ERR))
                cnt_memwait <= cnt_memwait + 32'd1;
            if (ifid_flush_c)
                cnt_flush <= cnt_flush + 32'd1;
        end
    end

    assign hz.perf_lduse   = cnt_lduse;
    assign hz.perf_memwait = cnt_memwait;
    assign hz.perf_flush   = cnt_flush;
`else
    assign hz.perf_lduse   = '0;
    assign hz.perf_memwait = '0;
    assign hz.perf_flush   = '0;
`endif
endmodule
